// File: rtl/demux1to2_31_buffered.sv
// demux1to2_31_buffered
//
// Buffered 1-to-2 demultiplexer. A single producer sends a WIDTH-bit word
// together with a per-word select bit. The word is written into one of two
// independent lane FIFOs, each holding DEPTH entries. Each lane drains to its
// own consumer through a valid/ready handshake. A stalled consumer only
// blocks its own lane.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset (empties both lanes)
//   in_data     word to distribute
//   in_select   destination lane (0 -> lane 0, 1 -> lane 1)
//   in_valid    producer has a word
//   in_ready    selected lane has room (registered counts only, 0 in reset)
//   out0_data   head of lane 0 (0 when lane 0 is empty)
//   out0_valid  lane 0 non-empty
//   out0_ready  lane 0 consumer accepts
//   out1_data   head of lane 1 (0 when lane 1 is empty)
//   out1_valid  lane 1 non-empty
//   out1_ready  lane 1 consumer accepts
//   count0      lane 0 occupancy, 0..DEPTH
//   count1      lane 1 occupancy, 0..DEPTH

module demux1to2_31_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [PTR_W:0]   count0,
    output logic [PTR_W:0]   count1
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [PTR_W:0]   count  [2];

    logic [1:0] lane_full;
    logic [1:0] lane_valid;
    logic [1:0] push;
    logic [1:0] pop;

    // in_ready looks only at the select bit and the registered counts. It
    // never looks at the consumer ready inputs. As a result, a full lane
    // refuses a push even in a cycle where it is also popping.
    always_comb begin
        lane_full  = '0;
        lane_valid = '0;
        push       = '0;
        pop        = '0;

        lane_full[0]  = (count[0] == FULL_COUNT);
        lane_full[1]  = (count[1] == FULL_COUNT);
        lane_valid[0] = (count[0] != '0);
        lane_valid[1] = (count[1] != '0);

        in_ready = !reset && (in_select ? !lane_full[1] : !lane_full[0]);

        push[0] = in_valid && in_ready && !in_select;
        push[1] = in_valid && in_ready &&  in_select;
        pop[0]  = lane_valid[0] && out0_ready;
        pop[1]  = lane_valid[1] && out1_ready;
    end

    // The pointers wrap naturally because DEPTH == 2**PTR_W. The count is
    // what tells a full lane apart from an empty one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + (PTR_W + 1)'(1);
                    2'b01:   count[i] <= count[i] - (PTR_W + 1)'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage is not reset. Stale entries are hidden by masking the outputs
    // with the lane-valid flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i] && !reset) begin
                mem[i][wr_ptr[i]] <= in_data;
            end
        end
    end

    assign out0_valid = lane_valid[0];
    assign out1_valid = lane_valid[1];
    assign out0_data  = lane_valid[0] ? mem[0][rd_ptr[0]] : '0;
    assign out1_data  = lane_valid[1] ? mem[1][rd_ptr[1]] : '0;
    assign count0     = count[0];
    assign count1     = count[1];

endmodule

// File: tb/tb_demux1to2_31_buffered.sv
// tb_demux1to2_31_buffered
//
// Self-checking bench for demux1to2_31_buffered. It has three phases:
//   1. A table of directed vectors with hand-derived expected outputs.
//   2. A drain/wrap sequence checked against a queue-based lane model.
//   3. Randomized traffic checked against the same model.

module tb_demux1to2_31_buffered;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [PTR_W:0]   count0;
    logic [PTR_W:0]   count1;

    demux1to2_31_buffered #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .count0    (count0),
        .count1    (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        sel;
        logic [31:0] data;
        logic        r0;
        logic        r1;
        logic        chk;
        logic        rdy;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic [1:0]  c0;
        logic [1:0]  c1;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model. Each lane is a plain word queue.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        last_push;

    // Words actually seen leaving lane 0 during the drain test.
    logic [31:0] seen0[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add_vec(input logic rst, input logic vld, input logic sel, input logic [31:0] data,
                           input logic r0, input logic r1, input logic chk, input logic rdy,
                           input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1,
                           input logic [1:0] c0, input logic [1:0] c1);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
        v.chk = chk; v.rdy = rdy; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.c0 = c0; v.c1 = c1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic vld, input logic sel, input logic [31:0] data,
                         input logic r0, input logic r1);
        reset      = rst;
        in_valid   = vld;
        in_select  = sel;
        in_data    = data;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Compares every DUT output against what the lane queues predict.
    task automatic checkOutput(input string tag);
        logic        exp_rdy;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        exp_rdy = !reset && (in_select ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
        exp_d0  = (q0.size() != 0) ? q0[0] : 32'h0;
        exp_d1  = (q1.size() != 0) ? q1[0] : 32'h0;
        check({tag, " in_ready"},   32'(in_ready),   32'(exp_rdy));
        check({tag, " out0_valid"}, 32'(out0_valid), 32'(q0.size() != 0));
        check({tag, " out0_data"},  out0_data,       exp_d0);
        check({tag, " out1_valid"}, 32'(out1_valid), 32'(q1.size() != 0));
        check({tag, " out1_data"},  out1_data,       exp_d1);
        check({tag, " count0"},     32'(count0),     q0.size());
        check({tag, " count1"},     32'(count1),     q1.size());
    endtask

    // Runs one model-checked cycle, then advances the queues to match the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic vld, input logic sel,
                                 input logic [31:0] data, input logic r0, input logic r1);
        logic acc;
        drive(rst, vld, sel, data, r0, r1);
        #1;
        checkOutput(tag);
        if (r0 && q0.size() != 0) seen0.push_back(out0_data);
        acc = !rst && vld && (sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0 && q0.size() != 0) void'(q0.pop_front());
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (acc && !sel) q0.push_back(data);
            if (acc &&  sel) q1.push_back(data);
        end
        last_push = acc;
        #1;
    endtask

    initial begin
        int          nxt;
        int          guard;
        string       tag;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        //        rst  vld  sel  data          r0   r1   chk  rdy  v0   d0            v1   d1            c0    c1
        // Reset and idle
        add_vec(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        // Steering and latency
        add_vec(1'b0,1'b1,1'b0,32'h000A0001, 1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b1,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b1,1'b1,1'b1,32'h000A0001, 1'b0,32'h0,        2'd1,2'd0);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,32'h000A0001, 1'b1,32'hDEADBEEF, 2'd1,2'd1);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b1,32'h000A0001, 1'b1,32'hDEADBEEF, 2'd1,2'd1);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        // Full lane, backpressure isolation
        add_vec(1'b0,1'b1,1'b0,32'h1,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b1,1'b0,32'h2,        1'b0,1'b0,1'b1,1'b1,1'b1,32'h1,        1'b0,32'h0,        2'd1,2'd0);
        add_vec(1'b0,1'b1,1'b0,32'h3,        1'b0,1'b0,1'b1,1'b0,1'b1,32'h1,        1'b0,32'h0,        2'd2,2'd0);
        add_vec(1'b0,1'b1,1'b1,32'h3,        1'b0,1'b0,1'b1,1'b1,1'b1,32'h1,        1'b0,32'h0,        2'd2,2'd0);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b1,32'h1,        1'b1,32'h3,        2'd2,2'd1);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b0,1'b1,32'h1,        1'b1,32'h3,        2'd2,2'd1);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b1,1'b1,32'h2,        1'b0,32'h0,        2'd1,2'd0);
        // Full plus pop on lane 1
        add_vec(1'b0,1'b1,1'b1,32'hA1,       1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b1,1'b1,32'hA2,       1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA1,       2'd0,2'd1);
        add_vec(1'b0,1'b1,1'b1,32'hA3,       1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'hA1,       2'd0,2'd2);
        add_vec(1'b0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA2,       2'd0,2'd1);
        add_vec(1'b0,1'b0,1'b1,32'h0,        1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA2,       2'd0,2'd1);
        // Reset mid-operation
        add_vec(1'b0,1'b1,1'b0,32'hB0,       1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);
        add_vec(1'b0,1'b1,1'b0,32'hB1,       1'b0,1'b0,1'b1,1'b1,1'b1,32'hB0,       1'b0,32'h0,        2'd1,2'd0);
        add_vec(1'b0,1'b1,1'b1,32'hC0,       1'b0,1'b0,1'b1,1'b1,1'b1,32'hB0,       1'b0,32'h0,        2'd2,2'd0);
        add_vec(1'b0,1'b1,1'b1,32'hC1,       1'b0,1'b0,1'b1,1'b1,1'b1,32'hB0,       1'b1,32'hC0,       2'd2,2'd1);
        add_vec(1'b1,1'b1,1'b0,32'hEE,       1'b1,1'b1,1'b1,1'b0,1'b1,32'hB0,       1'b1,32'hC0,       2'd2,2'd2);
        add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        2'd0,2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
            #1;
            if (vecs[i].chk) begin
                tag = $sformatf("vec%0d", i);
                check({tag, " in_ready"},   32'(in_ready),   32'(vecs[i].rdy));
                check({tag, " out0_valid"}, 32'(out0_valid), 32'(vecs[i].v0));
                check({tag, " out0_data"},  out0_data,       vecs[i].d0);
                check({tag, " out1_valid"}, 32'(out1_valid), 32'(vecs[i].v1));
                check({tag, " out1_data"},  out1_data,       vecs[i].d1);
                check({tag, " count0"},     32'(count0),     32'(vecs[i].c0));
                check({tag, " count1"},     32'(count1),     32'(vecs[i].c1));
            end
            @(posedge clk);
            #1;
        end

        // Drain order and wrap: lane 0 is preloaded with 0x10 and 0x11, then
        // drained while 0x12..0x17 are offered every cycle.
        q0.delete();
        q1.delete();
        seen0.delete();
        applyStimulus("fill0", 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
        applyStimulus("fill1", 1'b0, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        nxt   = 32'h12;
        guard = 0;
        while ((nxt <= 32'h17 || q0.size() != 0) && guard < 40) begin
            applyStimulus("drain", 1'b0, (nxt <= 32'h17), 1'b0, 32'(nxt), 1'b1, 1'b0);
            if (last_push) nxt++;
            guard++;
        end
        check("drain timeout", 32'(guard < 40), 32'd1);
        check("drain count", seen0.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < seen0.size()) check($sformatf("drain word%0d", i), seen0[i], 32'(32'h10 + i));
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                          $urandom, ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
